// File: rtl/s1423_cmp_count_if.sv
// s1423_cmp_count_if: control/data bundle for the compare-and-count block
//   master drives: en start ack sel din_a load_b din_b ref_load ref_din cnt_clr
//   slave drives:  cnt hit wrap done state
interface s1423_cmp_count_if #(
  parameter int W  = 5,
  parameter int CW = 8
);
  logic          en;
  logic          start;
  logic          ack;
  logic          sel;
  logic [W-1:0]  din_a;
  logic          load_b;
  logic [W-1:0]  din_b;
  logic          ref_load;
  logic [W-1:0]  ref_din;
  logic          cnt_clr;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          wrap;
  logic          done;
  logic [1:0]    state;
  modport master (
    output en, start, ack, sel, din_a, load_b, din_b, ref_load, ref_din, cnt_clr,
    input  cnt, hit, wrap, done, state
  );
  modport slave (
    input  en, start, ack, sel, din_a, load_b, din_b, ref_load, ref_din, cnt_clr,
    output cnt, hit, wrap, done, state
  );
endinterface

// File: rtl/s1423_cmp_count.sv
// s1423_cmp_count: registered unsigned compare feeding an FSM-gated event counter
//   CK  clock, RN synchronous active-low reset
//   bus slave side of s1423_cmp_count_if (operand/reference inputs, counter status outputs)
module s1423_cmp_count #(
  parameter int W     = 5,
  parameter int CW    = 8,
  parameter bit SAT   = 1'b0,
  parameter int LIMIT = 2**CW-1
) (
  input  logic               CK,
  input  logic               RN,
  s1423_cmp_count_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;
  localparam logic [CW-1:0] LIM = CW'(LIMIT);
  state_t        state_q, state_d;
  logic [W-1:0]  b_q, ref_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          hit_q, wrap_q, wrap_d, inc, top, to_done;
  assign top     = &cnt_q;
  assign inc     = (state_q == COUNT) && bus.en && hit_q;
  assign cnt_inc = (top && SAT) ? cnt_q : cnt_q + 1'b1;
  // a clear edge skips the terminal check; otherwise leave on reaching LIMIT or if already past it
  assign to_done = !bus.cnt_clr && ((cnt_q >= LIM) || (inc && cnt_inc == LIM));
  always_comb begin
    cnt_d   = bus.cnt_clr ? '0 : inc ? cnt_inc : cnt_q;
    wrap_d  = !bus.cnt_clr && inc && (SAT ? (!top && &cnt_inc) : top);
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = bus.start ? ARMED : IDLE;
      ARMED: state_d = hit_q ? COUNT : ARMED;
      COUNT: state_d = to_done ? DONE : COUNT;
      DONE:  state_d = bus.ack ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge CK) begin
    if (!RN) begin
      b_q     <= '0;
      ref_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      wrap_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      b_q     <= bus.load_b ? bus.din_b : b_q;
      ref_q   <= bus.ref_load ? bus.ref_din : ref_q;
      cnt_q   <= cnt_d;
      hit_q   <= (bus.sel ? b_q : bus.din_a) >= ref_q;
      wrap_q  <= wrap_d;
      state_q <= state_d;
    end
  end
  assign bus.cnt   = cnt_q;
  assign bus.hit   = hit_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = state_q == DONE;
  assign bus.state = state_q;
endmodule

// File: tb/tb_s1423_cmp_count.sv
// tb_s1423_cmp_count: three configurations (wrap/255, saturate/255, wrap/3) driven in lockstep
module tb_s1423_cmp_count;
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       en = 1'b0, start = 1'b0, ack = 1'b0, sel = 1'b0;
  logic       load_b = 1'b0, ref_load = 1'b0, cnt_clr = 1'b0;
  logic [4:0] din_a = '0, din_b = '0, ref_din = '0;
  logic [7:0] cnt_o [3];
  logic [1:0] st_o [3];
  logic       hit_o [3], wrap_o [3], done_o [3];
  int         checks = 0, errors = 0;
  bit         sat_k [3] = '{1'b0, 1'b1, 1'b0};
  int         lim_k [3] = '{255, 255, 3};
  int         m_b, m_ref, m_cnt [3], m_st [3];
  bit         m_hit, m_wrap [3];
  always #5 CK = ~CK;
  for (genvar g = 0; g < 3; g++) begin : gi
    s1423_cmp_count_if #(.W(5), .CW(8)) bus ();
    s1423_cmp_count #(.W(5), .CW(8), .SAT(g == 1), .LIMIT(g == 2 ? 3 : 255)) dut (
      .CK(CK), .RN(RN), .bus(bus)
    );
    assign bus.en = en;
    assign bus.start = start;
    assign bus.ack = ack;
    assign bus.sel = sel;
    assign bus.din_a = din_a;
    assign bus.load_b = load_b;
    assign bus.din_b = din_b;
    assign bus.ref_load = ref_load;
    assign bus.ref_din = ref_din;
    assign bus.cnt_clr = cnt_clr;
    assign cnt_o[g] = bus.cnt;
    assign st_o[g] = bus.state;
    assign hit_o[g] = bus.hit;
    assign wrap_o[g] = bus.wrap;
    assign done_o[g] = bus.done;
  end
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // one clock of the reference model, then every output of every instance is compared
  task automatic tick();
    int op, c, nc, ns, n_cnt [3], n_st [3];
    bit w, inc, nh, n_wrap [3];
    op = sel ? m_b : int'(din_a);
    nh = op >= m_ref;
    for (int k = 0; k < 3; k++) begin
      c = m_cnt[k]; ns = m_st[k]; nc = c; w = 0;
      inc = m_st[k] == 2 && en && m_hit;
      if (cnt_clr) nc = 0;
      else if (inc) begin
        nc = c + 1;
        if (nc > 255) begin nc = sat_k[k] ? 255 : 0; w = !sat_k[k]; end
        else w = sat_k[k] && nc == 255;
      end
      if (m_st[k] == 0 && start) ns = 1;
      if (m_st[k] == 1 && m_hit) ns = 2;
      if (m_st[k] == 2 && !cnt_clr && (c >= lim_k[k] || (inc && nc == lim_k[k]))) ns = 3;
      if (m_st[k] == 3 && ack) ns = 0;
      n_cnt[k] = nc; n_st[k] = ns; n_wrap[k] = w;
    end
    @(posedge CK);
    #1;
    if (!RN) begin
      m_b = 0; m_ref = 0; m_hit = 0;
      for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_st[k] = 0; m_wrap[k] = 0; end
    end else begin
      if (load_b) m_b = int'(din_b);
      if (ref_load) m_ref = int'(ref_din);
      m_hit = nh;
      for (int k = 0; k < 3; k++) begin m_cnt[k] = n_cnt[k]; m_st[k] = n_st[k]; m_wrap[k] = n_wrap[k]; end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("cnt%0d", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
      check($sformatf("state%0d", k), 32'(st_o[k]), 32'(m_st[k]));
      check($sformatf("hit%0d", k), 32'(hit_o[k]), 32'(m_hit));
      check($sformatf("wrap%0d", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
      check($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_st[k] == 3));
    end
  endtask
  initial begin
    m_b = 0; m_ref = 0; m_hit = 0;
    for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_st[k] = 0; m_wrap[k] = 0; end
    tick(); tick();
    check("rst_cnt", 32'(cnt_o[0]), 0);
    check("rst_state", 32'(st_o[0]), 0);
    RN = 1; ref_load = 1; ref_din = 10; tick();
    ref_load = 0; din_a = 9; tick();
    check("cmp_9", 32'(hit_o[0]), 0);
    din_a = 10; tick();
    check("cmp_10", 32'(hit_o[0]), 1);
    din_a = 31; tick();
    check("cmp_31", 32'(hit_o[0]), 1);
    din_a = 0; tick();
    check("cmp_0", 32'(hit_o[0]), 0);
    load_b = 1; din_b = 20; ref_load = 1; ref_din = 20; tick();
    load_b = 0; ref_load = 0; sel = 1; start = 1; tick();
    check("armed", 32'(st_o[0]), 1);
    start = 0; en = 1; tick();
    check("count", 32'(st_o[0]), 2);
    check("cnt_lat", 32'(cnt_o[0]), 0);
    tick();
    check("cnt_1", 32'(cnt_o[0]), 1);
    tick(); tick();
    check("lim3_state", 32'(st_o[2]), 3);
    check("lim3_done", 32'(done_o[2]), 1);
    check("lim3_cnt", 32'(cnt_o[2]), 3);
    start = 1; tick();
    start = 0;
    check("start_in_done", 32'(st_o[2]), 3);
    for (int i = 0; i < 250; i++) tick();
    tick();
    check("sat0_ff", 32'(cnt_o[0]), 255);
    check("sat0_done", 32'(st_o[0]), 3);
    check("sat1_wrap", 32'(wrap_o[1]), 1);
    tick();
    check("sat1_wrap_once", 32'(wrap_o[1]), 0);
    ack = 1; tick();
    check("ack_idle", 32'(st_o[2]), 0);
    check("ack_done", 32'(done_o[2]), 0);
    ack = 0; start = 1; tick();
    start = 0; tick(); tick();
    check("wrap_cnt", 32'(cnt_o[0]), 0);
    check("wrap_pulse", 32'(wrap_o[0]), 1);
    check("sat_hold", 32'(cnt_o[1]), 255);
    tick();
    check("wrap_width", 32'(wrap_o[0]), 0);
    ack = 1; tick();
    ack = 0; start = 1; tick();
    start = 0; tick();
    cnt_clr = 1; tick();
    check("clr_cnt", 32'(cnt_o[1]), 0);
    check("clr_wrap", 32'(wrap_o[1]), 0);
    check("clr_state", 32'(st_o[0]), 2);
    cnt_clr = 0; tick(); tick();
    RN = 0; tick();
    check("rst_mid_cnt", 32'(cnt_o[0]), 0);
    check("rst_mid_state", 32'(st_o[0]), 0);
    RN = 1; sel = 0; din_a = 0; tick();
    check("rst_ref0_hit", 32'(hit_o[0]), 1);
    for (int i = 0; i < 3000; i++) begin
      RN = $urandom_range(63) != 0;
      en = $urandom_range(3) != 0;
      start = $urandom_range(3) == 0;
      ack = $urandom_range(3) == 0;
      sel = 1'($urandom);
      din_a = 5'($urandom);
      load_b = $urandom_range(7) == 0;
      din_b = 5'($urandom);
      ref_load = $urandom_range(7) == 0;
      ref_din = 5'($urandom);
      cnt_clr = $urandom_range(31) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/s1423_cmp_count.md
Name: s1423_cmp_count

Overview:
- Parametrised sequential successor to the s1423 compare/increment cone.
- Selects a W-bit operand from an external bus or an internal loadable register, and compares it unsigned against a programmable reference.
- A CW-bit event counter advances on qualified hits under a small FSM, with wrap or saturate mode.
- Sits beside the s1423 netlists as a registered, width-generic replacement for the flattened compare-and-count logic.

Parameters:
- W, 5, operand/reference width (bits), >=2
- CW, 8, counter width (bits), >=2
- SAT, 0, 1 = counter saturates at all-ones; 0 = counter wraps to 0
- LIMIT, 2**CW-1, terminal count that ends a COUNT session (1..2**CW-1)

Ports:
- CK  input  1  clock; all state updates on rising edge
- RN  input  1  reset, synchronous, active-low
- en  input  1  global count enable (gates increments only)
- start  input  1  arm request; honoured only in IDLE
- ack  input  1  acknowledges DONE, returns FSM to IDLE
- sel  input  1  operand select: 0 = din_a, 1 = b_q
- din_a  input  W  external operand
- load_b  input  1  capture din_b into b_q
- din_b  input  W  internal operand source
- ref_load  input  1  capture ref_din into ref_q
- ref_din  input  W  reference value
- cnt_clr  input  1  synchronous counter clear
- cnt  output  CW  event counter
- hit  output  1  registered compare result (operand >= ref_q)
- wrap  output  1  one-cycle pulse on wrap (SAT=0) or on first reaching all-ones (SAT=1)
- done  output  1  high while FSM in DONE
- state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 COUNT, 3 DONE

Behaviour:
- Reset (RN=0 at edge): b_q=0, ref_q=0, cnt=0, hit=0, wrap=0, done=0, state=IDLE. Reset overrides every other input, in any state.
- Registers: b_q<=din_b when load_b; ref_q<=ref_din when ref_load. The new value becomes visible the cycle after the edge.
- Compare: op = sel ? b_q : din_a. hit <= (op >= ref_q) every cycle, unsigned, full W bits, using pre-edge ref_q/b_q. Latency 1 cycle.
- FSM:
  - IDLE: start -> ARMED; otherwise stay.
  - ARMED: hit=1 -> COUNT; otherwise stay.
  - COUNT: increments when en&hit. The increment that makes cnt==LIMIT moves to DONE in the same edge. cnt already >=LIMIT on entry -> DONE next edge.
  - DONE: ack -> IDLE; otherwise stay. done = (state==DONE).
- Increment: cnt <= cnt+1 only in COUNT with en=1 and hit=1. Net latency from operand change to count change is 2 edges.
- Width/overflow:
  - SAT=0: all-ones+1 -> 0, and wrap=1 for that cycle.
  - SAT=1: cnt holds at all-ones; wrap=1 only on the increment that reaches all-ones.
- cnt_clr: cnt<=0 in any state; overrides the increment on the same edge. FSM is unaffected except that DONE is not re-evaluated. wrap=0 on a clear edge.
- start outside IDLE and ack outside DONE are ignored.
- en=0 freezes cnt only; hit, registers and FSM still update.
- ref_load, load_b and compare on the same edge: the compare uses the old values.
- wrap defaults to 0 every cycle except as above.

Test Plan:
- Reset mid-COUNT (cnt=0x23, state=2), RN=0 one edge -> cnt=0, state=0, hit=0, done=0; b_q and ref_q read 0 via the compare (ref 0 -> hit=1 next cycle).
- ref_load 5'd10, sel=0, din_a 9 then 10 then 31 -> hit = 0, 1, 1, each one cycle after the operand. Then ref 10, din_a 0 -> hit=0.
- load_b 5'd20, sel=1, ref 20, start, en=1 held 4 cycles -> state ARMED->COUNT, cnt increments 1 per cycle starting 2 edges after hit rises.
- SAT=0, LIMIT=255, cnt preloaded to 0xFE via counting, hit held -> cnt 0xFF then DONE; separate run with LIMIT unreachable, cnt 0xFF->0x00 with wrap pulse width exactly 1.
- SAT=1: cnt reaches 0xFF, further hits -> cnt stays 0xFF, wrap pulses once. cnt_clr with en&hit on the same edge -> cnt=0, wrap=0.
- LIMIT=3: after 3 qualified hits -> state=DONE, done=1. start in DONE ignored; ack -> IDLE next edge, done=0.
